// File: rtl/data_memory_responder_if.sv
// Request/response bus between the core's data port and the data memory responder.
// The master is the requester (core side); the slave is the memory side.
interface data_memory_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_memory_responder.sv
// Data RAM behind a valid/ready port with programmable wait-state latency.
// One word-aligned access in flight at a time; stores are byte-enabled.
module data_memory_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    data_memory_responder_if.slave bus,
    input  logic [DEPTH-1:0][31:0] initial_values,
    output logic [DEPTH-1:0][31:0] memory_check
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state_q;
    logic [3:0]             count_q;
    logic                   write_q;
    logic [31:0]            addr_q;
    logic [31:0]            wdata_q;
    logic [3:0]             wstrb_q;
    logic                   req_ready_q;
    logic                   rsp_valid_q;
    logic [31:0]            rsp_rdata_q;
    logic                   rsp_error_q;
    logic [DEPTH-1:0][31:0] mem_q;

    logic                   accept;
    logic                   access_now;
    logic                   acc_write;
    logic [31:0]            acc_addr;
    logic [31:0]            acc_wdata;
    logic [3:0]             acc_wstrb;
    logic                   acc_err;
    logic [AW-1:0]          acc_idx;
    logic [31:0]            acc_old;
    logic [31:0]            acc_merged;

    // With zero latency the access happens on the acceptance edge, so it must
    // use the live request fields instead of the latched copy.
    always_comb begin
        acc_write = write_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_wstrb = wstrb_q;
        if (LATENCY == 0) begin
            acc_write = bus.req_write;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_wstrb = bus.req_wstrb;
        end
        accept     = (state_q == IDLE) && bus.req_valid && req_ready_q;
        access_now = (LATENCY == 0) ? accept : ((state_q == WAIT) && (count_q == 4'd0));
        acc_err    = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
        acc_idx    = acc_addr[AW+1:2];
        acc_old    = mem_q[acc_idx];
        for (int i = 0; i < 4; i++) begin
            acc_merged[8*i +: 8] = acc_wstrb[i] ? acc_wdata[8*i +: 8] : acc_old[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= 4'd0;
            write_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_error_q <= 1'b0;
            mem_q       <= initial_values;
        end else begin
            if (access_now) begin
                rsp_valid_q <= 1'b1;
                rsp_error_q <= acc_err;
                rsp_rdata_q <= (acc_err || acc_write) ? 32'd0 : acc_old;
                if (!acc_err && acc_write) begin
                    mem_q[acc_idx] <= acc_merged;
                end
            end
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        write_q     <= bus.req_write;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        wstrb_q     <= bus.req_wstrb;
                        if (LATENCY == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            count_q <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (count_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_error_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
    assign memory_check  = mem_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance at LATENCY=2 for the
// main load/store/error/reset checks, one at LATENCY=0 for back-to-back timing.
module tb_data_memory_responder;

    localparam int DEPTH = 32;

    logic                   clk;
    logic                   reset;
    logic [DEPTH-1:0][31:0] initial_values;
    logic [DEPTH-1:0][31:0] memCheck2;
    logic [DEPTH-1:0][31:0] memCheck0;
    logic [31:0]            model [DEPTH];

    int total = 0;
    int bad   = 0;

    data_memory_responder_if bus2 ();
    data_memory_responder_if bus0 ();

    data_memory_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus2),
        .initial_values (initial_values),
        .memory_check   (memCheck2)
    );

    data_memory_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus0),
        .initial_values (initial_values),
        .memory_check   (memCheck0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one request on the LATENCY=2 port, holds rsp_ready low for
    // holdCycles extra cycles, then completes the response handshake.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input int holdCycles,
                                 output logic [31:0] rdata, output logic err, output int lat,
                                 output logic [31:0] memAtRsp);
        int n;
        @(negedge clk);
        bus2.req_valid = 1'b1;
        bus2.req_write = wr;
        bus2.req_addr  = addr;
        bus2.req_wdata = wdata;
        bus2.req_wstrb = wstrb;
        bus2.rsp_ready = 1'b0;
        n = 0;
        while (!bus2.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_ready_before_accept", bus2.req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        lat = 1;
        while (!bus2.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata    = bus2.rsp_rdata;
        err      = bus2.rsp_error;
        memAtRsp = memCheck2[addr[6:2]];
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", bus2.rsp_valid, 1'b1);
            checkOutput("hold_rdata", bus2.rsp_rdata, rdata);
            checkOutput("hold_error", bus2.rsp_error, err);
        end
        bus2.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus2.rsp_ready = 1'b0;
        checkOutput("req_ready_after_rsp", bus2.req_ready, 1'b1);
        checkOutput("rsp_valid_after_rsp", bus2.rsp_valid, 1'b0);
    endtask

    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [31:0] memAtRsp;
    int          diffs;
    int          accepts;
    logic        prevReady;
    int          sawValid;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            initial_values[k] = 32'(k * 16 + 1);
            model[k]          = 32'(k * 16 + 1);
        end
        bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0;
        bus2.req_wdata = '0;   bus2.req_wstrb = '0;   bus2.rsp_ready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0;
        bus0.req_wdata = '0;   bus0.req_wstrb = '0;   bus0.rsp_ready = 1'b0;
        reset = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", bus2.req_ready, 1'b0);
        checkOutput("reset_rsp_valid", bus2.rsp_valid, 1'b0);
        checkOutput("reset_rsp_rdata", bus2.rsp_rdata, 32'h0);
        checkOutput("reset_mem5", memCheck2[5], 32'h51);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", bus2.req_ready, 1'b1);
        checkOutput("ready_after_reset_lat0", bus0.req_ready, 1'b1);
        checkOutput("rsp_valid_after_reset", bus2.rsp_valid, 1'b0);

        // Load with latency and a stalled response
        applyStimulus(1'b0, 32'h14, 32'h0, 4'h0, 3, rdata, err, lat, memAtRsp);
        checkOutput("load14_latency", 32'(lat), 32'd3);
        checkOutput("load14_rdata", rdata, 32'h51);
        checkOutput("load14_error", {31'd0, err}, 32'd0);

        // Full-word store then byte-enabled store
        applyStimulus(1'b1, 32'h08, 32'h11223344, 4'hF, 0, rdata, err, lat, memAtRsp);
        model[2] = 32'h11223344;
        checkOutput("store_full_mem2", memAtRsp, 32'h11223344);
        checkOutput("store_full_rdata", rdata, 32'h0);
        applyStimulus(1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, 0, rdata, err, lat, memAtRsp);
        model[2] = 32'h11BB33DD;
        checkOutput("store_strb_mem2_at_rsp", memAtRsp, 32'h11BB33DD);
        checkOutput("store_strb_rdata", rdata, 32'h0);
        checkOutput("store_strb_error", {31'd0, err}, 32'd0);
        checkOutput("store_strb_latency", 32'(lat), 32'd3);
        applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 0, rdata, err, lat, memAtRsp);
        checkOutput("load08_rdata", rdata, 32'h11BB33DD);

        // No-op store
        applyStimulus(1'b1, 32'h08, 32'hFFFFFFFF, 4'b0000, 0, rdata, err, lat, memAtRsp);
        checkOutput("noop_store_mem2", memCheck2[2], 32'h11BB33DD);
        checkOutput("noop_store_error", {31'd0, err}, 32'd0);

        // Last valid word
        applyStimulus(1'b0, 32'h7C, 32'h0, 4'h0, 0, rdata, err, lat, memAtRsp);
        checkOutput("load7c_rdata", rdata, 32'h1F1);
        checkOutput("load7c_error", {31'd0, err}, 32'd0);

        // Errors
        applyStimulus(1'b0, 32'h06, 32'h0, 4'h0, 1, rdata, err, lat, memAtRsp);
        checkOutput("misaligned_error", {31'd0, err}, 32'd1);
        checkOutput("misaligned_rdata", rdata, 32'h0);
        applyStimulus(1'b1, 32'h80, 32'hCAFEF00D, 4'hF, 0, rdata, err, lat, memAtRsp);
        checkOutput("oob_store_error", {31'd0, err}, 32'd1);
        checkOutput("oob_store_rdata", rdata, 32'h0);
        diffs = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (memCheck2[k] !== model[k]) diffs++;
        end
        checkOutput("mem_vs_model", 32'(diffs), 32'd0);

        // LATENCY=0 back-to-back with req_valid and rsp_ready held high
        @(negedge clk);
        bus0.req_valid = 1'b1;
        bus0.req_write = 1'b0;
        bus0.req_addr  = 32'h14;
        bus0.rsp_ready = 1'b1;
        accepts   = 0;
        prevReady = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (n > 0) begin
                checkOutput("lat0_rsp_follows_accept", bus0.rsp_valid, prevReady);
                if (bus0.rsp_valid) checkOutput("lat0_rdata", bus0.rsp_rdata, 32'h51);
            end
            prevReady = bus0.req_ready;
            if (bus0.req_ready) accepts++;
            @(negedge clk);
        end
        checkOutput("lat0_accept_count", 32'(accepts), 32'd6);
        bus0.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        bus0.rsp_ready = 1'b0;

        // Reset during WAIT discards the pending store
        @(negedge clk);
        bus2.req_valid = 1'b1;
        bus2.req_write = 1'b1;
        bus2.req_addr  = 32'h0C;
        bus2.req_wdata = 32'hDEADBEEF;
        bus2.req_wstrb = 4'hF;
        bus2.rsp_ready = 1'b1;
        checkOutput("midreset_ready", bus2.req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("midreset_rsp_valid", bus2.rsp_valid, 1'b0);
        checkOutput("midreset_req_ready", bus2.req_ready, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sawValid = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus2.rsp_valid) sawValid++;
        end
        checkOutput("midreset_no_rsp", 32'(sawValid), 32'd0);
        checkOutput("midreset_mem3", memCheck2[3], 32'h31);
        checkOutput("midreset_mem2_reloaded", memCheck2[2], 32'h21);
        bus2.rsp_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
